wb_retire_trace: RTL and testbench

Retirement trace unit at the far end of the MEM/WB pipeline register. Every cycle it reads the MEM/WB fields, recognises a retiring instruction, and reconstructs its PC, destination register and final write-back value. It queues one trace record per retirement in a small FIFO and presents records on a valid/ready port for the debug bench or the co-simulation checker. It also keeps retirement and drop counters.

---
 rtl/wb_retire_trace.sv | 87 ++++++++
 tb/tb_wb_retire_trace.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_retire_trace.sv
// Retirement trace unit: captures retiring MEM/WB instructions into a small FIFO
// and presents them on a valid/ready port, with retirement and drop counters.
module wb_retire_trace #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       trace_en,
  input  logic                       wb_RegWrite,
  input  logic                       wb_MemtoReg,
  input  logic [31:0]                wb_Pc_Four,
  input  logic [31:0]                wb_Alu_Result,
  input  logic [31:0]                wb_MemReadData,
  input  logic [4:0]                 wb_rd,
  input  logic [31:0]                wb_Curr_Instr,
  input  logic                       trace_ready,
  output logic                       trace_valid,
  output logic [8:0]                 trace_pc,
  output logic [31:0]                trace_instr,
  output logic                       trace_we,
  output logic [4:0]                 trace_rd,
  output logic [31:0]                trace_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [31:0]                retire_count,
  output logic [15:0]                drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = 79;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;

  logic          retire, push, pop;
  logic          rec_we;
  logic [31:0]   pc_full;
  logic [22:0]   unused_pc_hi;
  logic [4:0]    rec_rd;
  logic [31:0]   rec_data;
  logic [RW-1:0] rec;

  assign retire   = trace_en && (wb_Curr_Instr != 32'h0);
  assign pop      = trace_valid && trace_ready;
  // Simultaneous pop frees a slot, so a full FIFO still accepts the push.
  assign push     = retire && ((level < FULL_LEVEL) || pop);

  assign pc_full      = wb_Pc_Four - 32'd4;
  assign unused_pc_hi = pc_full[31:9];
  assign rec_we       = wb_RegWrite && (wb_rd != 5'd0);
  assign rec_rd       = rec_we ? wb_rd : 5'd0;
  assign rec_data     = !rec_we ? 32'd0 : (wb_MemtoReg ? wb_MemReadData : wb_Alu_Result);
  assign rec          = {pc_full[8:0], wb_Curr_Instr, rec_we, rec_rd, rec_data};

  assign trace_valid  = (level != '0);
  assign fifo_level   = level;
  assign {trace_pc, trace_instr, trace_we, trace_rd, trace_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      retire_count <= '0;
      drop_count   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (retire) begin
        retire_count <= retire_count + 32'd1;
        if (!push && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_retire_trace.sv
// Self-checking bench for wb_retire_trace: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_wb_retire_trace;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_en;
  logic        wb_RegWrite, wb_MemtoReg;
  logic [31:0] wb_Pc_Four, wb_Alu_Result, wb_MemReadData, wb_Curr_Instr;
  logic [4:0]  wb_rd;
  logic        trace_ready;
  logic        trace_valid;
  logic [8:0]  trace_pc;
  logic [31:0] trace_instr;
  logic        trace_we;
  logic [4:0]  trace_rd;
  logic [31:0] trace_data;
  logic [3:0]  fifo_level;
  logic [31:0] retire_count;
  logic [15:0] drop_count;

  wb_retire_trace #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .trace_en(trace_en),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_Pc_Four(wb_Pc_Four), .wb_Alu_Result(wb_Alu_Result),
    .wb_MemReadData(wb_MemReadData), .wb_rd(wb_rd),
    .wb_Curr_Instr(wb_Curr_Instr), .trace_ready(trace_ready),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_instr(trace_instr),
    .trace_we(trace_we), .trace_rd(trace_rd), .trace_data(trace_data),
    .fifo_level(fifo_level), .retire_count(retire_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } rec_t;

  rec_t        q[$];
  int unsigned exp_retire;
  int unsigned exp_drop;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic rec_t make_rec();
    rec_t r;
    r.pc    = 9'((wb_Pc_Four - 32'd4) % 32'd512);
    r.instr = wb_Curr_Instr;
    r.we    = wb_RegWrite && (wb_rd != 0);
    r.rd    = r.we ? wb_rd : 5'd0;
    r.data  = !r.we ? 32'd0 : (wb_MemtoReg ? wb_MemReadData : wb_Alu_Result);
    return r;
  endfunction

  // One clock: the model consumes the same inputs the DUT samples, then outputs are compared.
  task automatic tick();
    bit   ret, do_pop, was_full;
    rec_t r;
    @(posedge clk);
    if (reset) begin
      q.delete();
      exp_retire = 0;
      exp_drop   = 0;
    end else begin
      ret      = trace_en && (wb_Curr_Instr != 0);
      r        = make_rec();
      do_pop   = (q.size() != 0) && trace_ready;
      was_full = (q.size() == DEPTH);
      if (do_pop) void'(q.pop_front());
      if (ret) begin
        exp_retire++;
        if (!was_full || do_pop) q.push_back(r);
        else if (exp_drop < 32'hFFFF) exp_drop++;
      end
    end
    #1;
    chk("valid", trace_valid, q.size() != 0);
    chk("level", fifo_level, q.size());
    chk("retire_count", retire_count, exp_retire);
    chk("drop_count", drop_count, exp_drop);
    if (q.size() != 0) begin
      chk("pc", trace_pc, q[0].pc);
      chk("instr", trace_instr, q[0].instr);
      chk("we", trace_we, q[0].we);
      chk("rd", trace_rd, q[0].rd);
      chk("data", trace_data, q[0].data);
    end
  endtask

  task automatic set_ret(input logic [31:0] instr, input logic [31:0] pc4, input logic rw,
                         input logic m2r, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] mrd);
    wb_Curr_Instr = instr; wb_Pc_Four = pc4; wb_RegWrite = rw;
    wb_MemtoReg = m2r; wb_rd = rd; wb_Alu_Result = alu; wb_MemReadData = mrd;
  endtask

  task automatic rand_ret(input bit allow_bubble);
    logic [31:0] instr;
    instr = $urandom;
    if (instr == 0 || (!allow_bubble)) instr = instr | 32'h13;
    if (allow_bubble && ($urandom_range(0, 3) == 0)) instr = 0;
    set_ret(instr, $urandom, 1'($urandom), 1'($urandom),
            ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom);
  endtask

  task automatic bubble();
    set_ret(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; trace_en = 1'b1; trace_ready = 1'b0;
    bubble();
    tick(); tick();
    reset = 1'b0;
    chk("reset_valid", trace_valid, 1'b0);
    chk("reset_level", fifo_level, 4'd0);

    // Single retirement
    set_ret(32'h00A00093, 32'h10, 1'b1, 1'b0, 5'd1, 32'hA, 32'h0);
    tick();
    bubble();
    chk("t1_pc", trace_pc, 9'h00C);
    chk("t1_we", trace_we, 1'b1);
    chk("t1_rd", trace_rd, 5'd1);
    chk("t1_data", trace_data, 32'hA);
    chk("t1_level", fifo_level, 4'd1);
    chk("t1_retire", retire_count, 32'd1);
    trace_ready = 1'b1; tick(); trace_ready = 1'b0;
    chk("t1_drained", trace_valid, 1'b0);

    // Load, bubble, x0 write
    do_reset();
    set_ret(32'h0002A283, 32'h24, 1'b1, 1'b1, 5'd5, 32'h1234, 32'hDEADBEEF); tick();
    bubble(); tick();
    set_ret(32'h00100013, 32'h2C, 1'b1, 1'b0, 5'd0, 32'h1, 32'h0); tick();
    bubble(); tick();
    chk("t2_level", fifo_level, 4'd2);
    chk("t2_retire", retire_count, 32'd2);
    chk("t2_first_data", trace_data, 32'hDEADBEEF);
    trace_ready = 1'b1; tick(); trace_ready = 1'b0;
    chk("t2_second_we", trace_we, 1'b0);
    chk("t2_second_rd", trace_rd, 5'd0);
    chk("t2_second_data", trace_data, 32'd0);
    trace_ready = 1'b1; tick(); trace_ready = 1'b0;

    // Overflow then full push+pop
    do_reset();
    for (int i = 0; i < 10; i++) begin rand_ret(1'b0); tick(); end
    chk("ovf_level", fifo_level, 4'd8);
    chk("ovf_drop", drop_count, 16'd2);
    chk("ovf_retire", retire_count, 32'd10);
    trace_ready = 1'b1; rand_ret(1'b0); tick();
    chk("fullpp_level", fifo_level, 4'd8);
    chk("fullpp_drop", drop_count, 16'd2);
    bubble();
    for (int i = 0; i < 9; i++) tick();

    // Streaming with ready held high
    do_reset();
    trace_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_ret(1'b0); tick();
      chk("stream_level_le1", fifo_level <= 4'd1, 1'b1);
    end
    bubble(); tick();

    // Reset with records queued
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_ret(1'b0); tick(); end
    rand_ret(1'b0); do_reset(); bubble();
    chk("rst_valid", trace_valid, 1'b0);
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_drop", drop_count, 16'd0);

    // trace_en=0 ignores MEM/WB while draining continues
    rand_ret(1'b0); tick();
    trace_en = 1'b0; trace_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin rand_ret(1'b0); tick(); end
    chk("dis_retire", retire_count, 32'd1);
    chk("dis_level", fifo_level, 4'd0);
    trace_en = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      trace_en    = ($urandom_range(0, 7) != 0);
      trace_ready = ($urandom_range(0, 2) == 0);
      reset       = ($urandom_range(0, 99) == 0);
      rand_ret(1'b1);
      tick();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
